// File: rtl/wdf_stimulus_generator.sv
// Stimulus source for WDF filter cores: fixed-length runs of signed samples
// paced by an internal clock divider, delivered over a valid/ready handshake.
// Channel k carries the base pattern delayed by k samples.
// Optional feature macro: WDF_STIM_AUTO_LOOP_EN (restart automatically after
// each completed run; done pulses for one cycle per run, busy stays high).
module wdf_stimulus_generator #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned CLK_DIV       = 5,
  parameter int unsigned TOTAL_SAMPLES = 1000,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [2:0]                         mode,
  input  logic [DATA_WIDTH-1:0]              amplitude,
  input  logic [15:0]                        period,
  output logic                               sample_valid,
  input  logic                               sample_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
  output logic [CNT_WIDTH-1:0]               sample_index,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_WIDTH-1:0]               overrun_count
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DATA_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int unsigned PH_W   = 17;
  localparam logic [31:0] LFSR_SEED = 32'hACE12345;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(TOTAL_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] N_TOTAL  = CNT_WIDTH'(TOTAL_SAMPLES);
  localparam bit                   HAS_SAMPLES = (TOTAL_SAMPLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [2:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   amp_q, amp_d;
  logic [15:0]             per_q, per_d;
  logic                    sample_valid_q, sample_valid_d;
  logic [DATA_W-1:0]       sample_data_q, sample_data_d;
  logic [CNT_WIDTH-1:0]    sample_index_q, sample_index_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    overrun_q, overrun_d;

  logic                    tick;
  logic                    accept;
  logic                    pending;
  logic                    restart;
  logic                    load;
  logic [DATA_WIDTH-1:0]   base;
  logic [PH_W-1:0]         phase_last;

  assign sample_valid  = sample_valid_q;
  assign sample_data   = sample_data_q;
  assign sample_index  = sample_index_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun_count = overrun_q;

  // Base pattern value for the current sample n, from the latched settings
  always_comb begin
    base       = '0;
    phase_last = {per_q, 1'b0} - PH_W'(1);
    unique case (mode_q)
      3'd0: base = (n_q == '0) ? amp_q : '0;
      3'd1: base = amp_q;
      3'd2: base = acc_q;
      3'd3: base = (phase_q < {1'b0, per_q}) ? amp_q : ((~amp_q) + DATA_WIDTH'(1));
      3'd4: base = DATA_WIDTH'(lfsr_q);
      default: base = '0;
    endcase
  end

  // Next-state and datapath: run control, divider, sample generation, overrun
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    n_d            = n_q;
    acc_d          = acc_q;
    phase_d        = phase_q;
    lfsr_d         = lfsr_q;
    mode_d         = mode_q;
    amp_d          = amp_q;
    per_d          = per_q;
    sample_valid_d = sample_valid_q;
    sample_data_d  = sample_data_q;
    sample_index_d = sample_index_q;
    overrun_d      = overrun_q;
    restart        = 1'b0;
    load           = 1'b0;

    tick    = (state_q == ST_RUN) && (div_q == DIV_LAST);
    accept  = sample_valid_q && sample_ready;
    pending = sample_valid_q && !accept;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          restart = 1'b1;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        div_d = tick ? '0 : (div_q + DIV_W'(1));
        if (accept) begin
          sample_valid_d = 1'b0;
        end
        if (tick) begin
          if (pending) begin
            // Consumer still holds the previous sample: drop this tick
            if (overrun_q != '1) begin
              overrun_d = overrun_q + CNT_WIDTH'(1);
            end
          end else if (n_q != N_TOTAL) begin
            sample_data_d[0 +: DATA_WIDTH] = base;
            for (int k = 1; k < int'(NUM_CHANNELS); k++) begin
              sample_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                sample_data_q[(k-1)*DATA_WIDTH +: DATA_WIDTH];
            end
            sample_valid_d = 1'b1;
            sample_index_d = n_q;
            n_d            = n_q + CNT_WIDTH'(1);
            acc_d          = acc_q + amp_q;
            phase_d        = (phase_q == phase_last) ? '0 : (phase_q + PH_W'(1));
            lfsr_d         = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
          end
        end
        if (accept && (sample_index_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef WDF_STIM_AUTO_LOOP_EN
        restart = 1'b1;
        load    = start;
`else
        if (start) begin
          restart = 1'b1;
          load    = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Fresh run: clear pacing, pattern state and delay line
    if (restart) begin
      state_d        = HAS_SAMPLES ? ST_RUN : ST_DONE;
      div_d          = '0;
      n_d            = '0;
      acc_d          = '0;
      phase_d        = '0;
      lfsr_d         = LFSR_SEED;
      sample_valid_d = 1'b0;
      sample_data_d  = '0;
      sample_index_d = '0;
      overrun_d      = '0;
    end
    if (load) begin
      mode_d = mode;
      amp_d  = amplitude;
      per_d  = (period == 16'd0) ? 16'd1 : period;
    end
  end

  // Status outputs follow the state being entered
  always_comb begin
    done_d = (state_d == ST_DONE);
`ifdef WDF_STIM_AUTO_LOOP_EN
    busy_d = (state_d == ST_RUN) || ((state_d == ST_DONE) && HAS_SAMPLES);
`else
    busy_d = (state_d == ST_RUN);
`endif
  end

  // State and datapath registers with asynchronous abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      n_q            <= '0;
      acc_q          <= '0;
      phase_q        <= '0;
      lfsr_q         <= LFSR_SEED;
      mode_q         <= '0;
      amp_q          <= '0;
      per_q          <= 16'd1;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      sample_index_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      phase_q        <= phase_d;
      lfsr_q         <= lfsr_d;
      mode_q         <= mode_d;
      amp_q          <= amp_d;
      per_q          <= per_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      sample_index_q <= sample_index_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

endmodule
